// File: rtl/wts_channel_mixer_5ch_if.sv
`default_nettype none
// ============================================================================
// Module      : wts_channel_mixer_5ch_if
// Description : Bus bundle for the wave-table channel mixer: wave RAM read
//               port (address out, registered sample back) and the mixed
//               sample output with its one-cycle valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
interface wts_channel_mixer_5ch_if;
  logic [9:0]  ram_address;
  logic [7:0]  ram_q;
  logic [14:0] sound_out;
  logic        sound_valid;

  // Mixer side
  modport master (
    output ram_address,
    input  ram_q,
    output sound_out,
    output sound_valid
  );

  // RAM / audio-consumer side
  modport slave (
    input  ram_address,
    output ram_q,
    input  sound_out,
    input  sound_valid
  );
endinterface
`default_nettype wire

// File: rtl/wts_channel_mixer_5ch.sv
`default_nettype none
// ============================================================================
// Module      : wts_channel_mixer_5ch
// Description : Reading end of the 5-channel time-multiplexed tone generator.
//               Three-stage pipeline: address/volume capture, sample x volume
//               multiply, then accumulate slots 0..4 into one signed mix with
//               a one-cycle valid strobe.
//               Optional macro WTS_MIXER_CLIP_EN saturates the mix to the
//               signed 12-bit range before it reaches sound_out.
// Revision    : 1.0 - initial release
// ============================================================================
module wts_channel_mixer_5ch (
  input  logic                          clk,
  input  logic                          nreset,
  input  logic [2:0]                    active,
  input  logic [6:0]                    wave_address,
  input  logic [3:0]                    reg_volume_a,
  input  logic [3:0]                    reg_volume_b,
  input  logic [3:0]                    reg_volume_c,
  input  logic [3:0]                    reg_volume_d,
  input  logic [3:0]                    reg_volume_e,
  input  logic                          reg_enable_a,
  input  logic                          reg_enable_b,
  input  logic                          reg_enable_c,
  input  logic                          reg_enable_d,
  input  logic                          reg_enable_e,
  wts_channel_mixer_5ch_if.master       mix
);

  // Pipeline slot tags reset to an idle slot so no strobe fires after reset
  localparam logic [2:0] C_SLOT_IDLE = 3'd5;

  logic [3:0]         w_vol_sel;
  logic [2:0]         r_active_d1;
  logic [2:0]         r_active_d2;
  logic [3:0]         r_volume;
  logic signed [11:0] w_sample_ext;
  logic signed [11:0] w_volume_ext;
  logic signed [11:0] w_product;
  logic signed [11:0] r_product;
  logic signed [14:0] w_product_ext;
  logic signed [14:0] w_sum;
  logic signed [14:0] w_result;
  logic signed [14:0] r_acc;
  logic [14:0]        r_sound_out;
  logic               r_sound_valid;

  // Stage 0: RAM address is a straight concatenation, zero latency
  assign mix.ram_address = {active, wave_address};

  // Stage 0: pick the current slot's volume, forced to 0 when disabled or idle
  always_comb begin
    w_vol_sel = 4'd0;
    case (active)
      3'd0:    if (reg_enable_a) w_vol_sel = reg_volume_a;
      3'd1:    if (reg_enable_b) w_vol_sel = reg_volume_b;
      3'd2:    if (reg_enable_c) w_vol_sel = reg_volume_c;
      3'd3:    if (reg_enable_d) w_vol_sel = reg_volume_d;
      3'd4:    if (reg_enable_e) w_vol_sel = reg_volume_e;
      default: w_vol_sel = 4'd0;
    endcase
  end

  // Stage 0 capture: slot tag and effective volume travel alongside the RAM read
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_active_d1 <= C_SLOT_IDLE;
      r_volume    <= 4'd0;
    end else begin
      r_active_d1 <= active;
      r_volume    <= w_vol_sel;
    end
  end

  // Stage 1 operands widened to 12 bits; volume is zero-extended so it stays positive
  assign w_sample_ext = {{4{mix.ram_q[7]}}, mix.ram_q};
  assign w_volume_ext = {8'd0, r_volume};
  assign w_product    = w_sample_ext * w_volume_ext;

  // Stage 1: register the scaled sample (range -1920..1905) and its slot tag
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_product   <= 12'sd0;
      r_active_d2 <= C_SLOT_IDLE;
    end else begin
      r_product   <= w_product;
      r_active_d2 <= r_active_d1;
    end
  end

  assign w_product_ext = {{3{r_product[11]}}, r_product};
  assign w_sum         = r_acc + w_product_ext;

`ifdef WTS_MIXER_CLIP_EN
  localparam logic signed [14:0] C_CLIP_MAX = 15'sd2047;
  localparam logic signed [14:0] C_CLIP_MIN = -15'sd2048;

  // Saturate the finished mix to the signed 12-bit range
  always_comb begin
    w_result = w_sum;
    if (w_sum > C_CLIP_MAX) begin
      w_result = C_CLIP_MAX;
    end else if (w_sum < C_CLIP_MIN) begin
      w_result = C_CLIP_MIN;
    end
  end
`else
  assign w_result = w_sum;
`endif

  // Stage 2: slot 0 loads, 1..3 add, 4 publishes the mix, idle slots hold
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_acc         <= 15'sd0;
      r_sound_out   <= 15'd0;
      r_sound_valid <= 1'b0;
    end else begin
      r_sound_valid <= 1'b0;
      case (r_active_d2)
        3'd0:                r_acc <= w_product_ext;
        3'd1, 3'd2, 3'd3:    r_acc <= w_sum;
        3'd4: begin
          r_sound_out   <= w_result;
          r_sound_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mix.sound_out   = r_sound_out;
  assign mix.sound_valid = r_sound_valid;

endmodule
`default_nettype wire

// File: tb/tb_wts_channel_mixer_5ch.sv
`default_nettype none
// ============================================================================
// Module      : tb_wts_channel_mixer_5ch
// Description : Self-checking bench for wts_channel_mixer_5ch. A synchronous
//               wave RAM model feeds the mixer; a slot-level reference model
//               (integer arithmetic over a queue of slot events) predicts
//               sound_out / sound_valid. Honours WTS_MIXER_CLIP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wts_channel_mixer_5ch;

  logic       clk;
  logic       nreset;
  logic [2:0] active;
  logic [6:0] wave_address;
  logic [3:0] vol [5];
  logic       en  [5];
  logic [7:0] mem [1024];

  wts_channel_mixer_5ch_if mix_if ();

  wts_channel_mixer_5ch dut (
    .clk          (clk),
    .nreset       (nreset),
    .active       (active),
    .wave_address (wave_address),
    .reg_volume_a (vol[0]),
    .reg_volume_b (vol[1]),
    .reg_volume_c (vol[2]),
    .reg_volume_d (vol[3]),
    .reg_volume_e (vol[4]),
    .reg_enable_a (en[0]),
    .reg_enable_b (en[1]),
    .reg_enable_c (en[2]),
    .reg_enable_d (en[3]),
    .reg_enable_e (en[4]),
    .mix          (mix_if.master)
  );

  // Synchronous wave RAM: data valid the cycle after the address
  always @(posedge clk) mix_if.ram_q <= mem[mix_if.ram_address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: slot events age through the pipeline and then act
  typedef struct {
    int left;
    int slot;
    int val;
  } ev_t;

  ev_t pend[$];
  int  m_acc;
  int  m_out;
  int  m_valid;
  int  n_checks;
  int  n_pass;

  task automatic chk_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int wrap15(input int x);
    int w;
    w = x & 32'h7fff;
    if (w >= 16384) w = w - 32768;
    return w;
  endfunction

  function automatic int mix_final(input int x);
    int r;
    r = wrap15(x);
`ifdef WTS_MIXER_CLIP_EN
    if (r > 2047)  r = 2047;
    if (r < -2048) r = -2048;
`endif
    return r;
  endfunction

  function automatic int out_now();
    return int'($signed(mix_if.sound_out));
  endfunction

  // One slot: present it, predict its contribution, clock, then compare
  task automatic step(input logic [2:0] a, input logic [6:0] wa);
    int   c;
    ev_t  ev;
    logic [9:0] addr;
    @(negedge clk);
    active       = a;
    wave_address = wa;
    addr         = {a, wa};
    #1;
    chk_val("ram_address", int'(mix_if.ram_address), int'(addr));
    c = 0;
    if (a <= 3'd4) begin
      if (en[a]) c = int'($signed(mem[addr])) * int'(vol[a]);
    end
    pend.push_back('{3, int'(a), c});
    @(posedge clk);
    #1;
    m_valid = 0;
    foreach (pend[i]) pend[i].left--;
    if (pend.size() > 0 && pend[0].left == 0) begin
      ev = pend.pop_front();
      if (ev.slot == 0) begin
        m_acc = ev.val;
      end else if (ev.slot >= 1 && ev.slot <= 3) begin
        m_acc = wrap15(m_acc + ev.val);
      end else if (ev.slot == 4) begin
        m_out   = mix_final(m_acc + ev.val);
        m_valid = 1;
      end
    end
    chk_val("sound_valid", int'(mix_if.sound_valid), m_valid);
    chk_val("sound_out", out_now(), m_out);
  endtask

  task automatic run_period(input logic [6:0] wa);
    for (int s = 0; s < 8; s++) step(3'(s), wa);
  endtask

  task automatic fill_ch(input int ch, input logic [7:0] v);
    for (int i = 0; i < 128; i++) mem[ch * 128 + i] = v;
  endtask

  task automatic set_all(input logic [3:0] v, input logic e);
    for (int i = 0; i < 5; i++) begin
      vol[i] = v;
      en[i]  = e;
    end
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without waiting for a clock
  task automatic do_reset(input int cycles);
    #3;
    nreset = 1'b0;
    #1;
    chk_val("rst_sound_out", out_now(), 0);
    chk_val("rst_sound_valid", int'(mix_if.sound_valid), 0);
    pend.delete();
    m_acc  = 0;
    m_out  = 0;
    active = 3'd5;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;
  endtask

  initial begin
    int seq;
    n_checks     = 0;
    n_pass       = 0;
    m_acc        = 0;
    m_out        = 0;
    m_valid      = 0;
    nreset       = 1'b1;
    active       = 3'd5;
    wave_address = 7'd0;
    set_all(4'd0, 1'b0);
    for (int i = 0; i < 1024; i++) mem[i] = 8'd0;

    // Reset state
    #1;
    nreset = 1'b0;
    #1;
    chk_val("reset_sound_out", out_now(), 0);
    chk_val("reset_sound_valid", int'(mix_if.sound_valid), 0);
    chk_val("reset_ram_address", int'(mix_if.ram_address), 10'h280);
    repeat (3) @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;
    for (int i = 0; i < 4; i++) step(3'd5, 7'd0);

    // Channel a only: 0x40 * 15 = 960
    fill_ch(0, 8'h40);
    vol[0] = 4'd15;
    en[0]  = 1'b1;
    for (int p = 0; p < 3; p++) run_period(7'h11);
    chk_val("mix_a_only", out_now(), 960);

    // All channels at full negative scale
    for (int c = 0; c < 5; c++) fill_ch(c, 8'h80);
    set_all(4'd15, 1'b1);
    for (int p = 0; p < 2; p++) run_period(7'h22);
`ifdef WTS_MIXER_CLIP_EN
    chk_val("mix_all_neg", out_now(), -2048);
`else
    chk_val("mix_all_neg", out_now(), -9600);
`endif

    // All channels at full positive scale
    for (int c = 0; c < 5; c++) fill_ch(c, 8'h7f);
    for (int p = 0; p < 2; p++) run_period(7'h33);
`ifdef WTS_MIXER_CLIP_EN
    chk_val("mix_all_pos", out_now(), 2047);
`else
    chk_val("mix_all_pos", out_now(), 9525);
`endif

    // Channel c disabled, then enabled: 0x10 * 8 = 128
    for (int c = 0; c < 5; c++) fill_ch(c, 8'h00);
    fill_ch(2, 8'h10);
    set_all(4'd15, 1'b1);
    vol[2] = 4'd8;
    en[2]  = 1'b0;
    for (int p = 0; p < 2; p++) run_period(7'h05);
    chk_val("mix_c_disabled", out_now(), 0);
    en[2] = 1'b1;
    for (int p = 0; p < 2; p++) run_period(7'h05);
    chk_val("mix_c_enabled", out_now(), 128);

    // Address concatenation and a held idle slot
    step(3'd3, 7'h05);
    chk_val("ram_addr_3_05", int'(mix_if.ram_address), 10'h185);
    for (int i = 0; i < 10; i++) step(3'd6, 7'($urandom_range(0, 127)));

    // Reset while slot 2 sits in stage 1, then recover
    step(3'd0, 7'h05);
    step(3'd1, 7'h05);
    step(3'd2, 7'h05);
    do_reset(2);
    for (int s = 3; s < 8; s++) step(3'(s), 7'h05);
    run_period(7'h05);
    chk_val("mix_after_reset", out_now(), 128);

    // Randomised slot streams, samples, volumes and enables
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    seq = 0;
    for (int n = 0; n < 600; n++) begin
      if ((n % 8) == 0) begin
        for (int c = 0; c < 5; c++) begin
          vol[c] = 4'($urandom_range(0, 15));
          en[c]  = ($urandom_range(0, 3) != 0);
        end
      end
      if ($urandom_range(0, 9) < 8) begin
        step(3'(seq), 7'($urandom_range(0, 127)));
        seq = (seq + 1) % 8;
      end else begin
        step(3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
